// File: rtl/io_bus_responder_pkg.sv
// Shared definitions for the CPU I/O responder: register offsets, FSM encoding
// and the compare register's default.
package io_bus_responder_pkg;

  localparam logic [2:0] REG_DISP    = 3'd0;
  localparam logic [2:0] REG_LED     = 3'd1;
  localparam logic [2:0] REG_SW      = 3'd2;
  localparam logic [2:0] REG_BTN_EVT = 3'd3;
  localparam logic [2:0] REG_BTN_LVL = 3'd4;
  localparam logic [2:0] REG_TIMER   = 3'd5;
  localparam logic [2:0] REG_CMP     = 3'd6;
  localparam logic [2:0] REG_STATUS  = 3'd7;

  localparam logic [31:0] CMP_RESET_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/io_bus_responder_btn_edge_capture.sv
// Sticky rising-edge flags for debounced buttons; a new edge beats a clear
// arriving in the same cycle so no press is ever lost.
module btn_edge_capture #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] btn,
  input  logic [W-1:0] clr,
  output logic [W-1:0] evt
);

  logic [W-1:0] btn_q_reg;
  logic [W-1:0] evt_reg;
  logic [W-1:0] evt_next;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign evt_next[gi] = (btn[gi] & ~btn_q_reg[gi]) | (evt_reg[gi] & ~clr[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q_reg <= '0;
      evt_reg   <= '0;
    end else begin
      btn_q_reg <= btn;
      evt_reg   <= evt_next;
    end
  end

  assign evt = evt_reg;

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder: display/LED registers, switches, button events,
// free-running timer with sticky compare match, behind a one-access-per-request FSM.
module io_bus_responder
  import io_bus_responder_pkg::*;
#(
  parameter int          BTN_N     = 5,
  parameter int          SW_N      = 8,
  parameter logic [31:0] CMP_RESET = CMP_RESET_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_sel,
  input  logic [2:0]       io_addr,
  input  logic [31:0]      io_wdata,
  input  logic             io_wr,
  input  logic             io_rdn,
  output logic [31:0]      io_rdata,
  output logic             io_ready,
  input  logic [SW_N-1:0]  sw,
  input  logic [BTN_N-1:0] btn,
  output logic [31:0]      disp_num,
  output logic [7:0]       led
);

  state_t state_reg, state_next;

  logic [31:0]      disp_reg;
  logic [7:0]       led_reg;
  logic [31:0]      timer_reg;
  logic [31:0]      cmp_reg;
  logic             match_reg;
  logic [31:0]      rdata_reg;
  logic [31:0]      rd_mux;
  logic [BTN_N-1:0] evt;
  logic [BTN_N-1:0] evt_clr;

  logic req, accept, wr_acc, rd_acc;

  assign req    = io_sel & (io_wr | ~io_rdn);
  assign accept = (state_reg == ST_IDLE) & req;
  assign wr_acc = accept & io_wr;
  assign rd_acc = accept & ~io_wr;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req) state_next = ST_RESP;
      ST_RESP: state_next = ST_HOLD;
      // Wait for the CPU to drop its strobe so a held read is served once.
      ST_HOLD: if ((~io_wr & io_rdn) | ~io_sel) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (io_addr)
      REG_DISP:    rd_mux = disp_reg;
      REG_LED:     rd_mux = 32'(led_reg);
      REG_SW:      rd_mux = 32'(sw);
      REG_BTN_EVT: rd_mux = 32'(evt);
      REG_BTN_LVL: rd_mux = 32'(btn);
      REG_TIMER:   rd_mux = timer_reg;
      REG_CMP:     rd_mux = cmp_reg;
      REG_STATUS:  rd_mux = {31'b0, match_reg};
      default:     rd_mux = '0;
    endcase
  end

  // A read of BTN_EVT clears every flag; a write clears the flags written as 1.
  always_comb begin
    evt_clr = '0;
    if (accept && io_addr == REG_BTN_EVT)
      evt_clr = io_wr ? io_wdata[BTN_N-1:0] : '1;
  end

  btn_edge_capture #(.W(BTN_N)) u_btn_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .clr   (evt_clr),
    .evt   (evt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      disp_reg  <= '0;
      led_reg   <= '0;
      timer_reg <= '0;
      cmp_reg   <= CMP_RESET;
      match_reg <= 1'b0;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;

      if (wr_acc && io_addr == REG_DISP) disp_reg <= io_wdata;
      if (wr_acc && io_addr == REG_LED)  led_reg  <= io_wdata[7:0];
      if (wr_acc && io_addr == REG_CMP)  cmp_reg  <= io_wdata;

      if (wr_acc && io_addr == REG_TIMER) timer_reg <= io_wdata;
      else                                timer_reg <= timer_reg + 32'd1;

      if (timer_reg == cmp_reg)                              match_reg <= 1'b1;
      else if (wr_acc && io_addr == REG_STATUS && io_wdata[0]) match_reg <= 1'b0;

      // A write colliding with a read drops the read and returns zero.
      if (rd_acc)               rdata_reg <= rd_mux;
      else if (wr_acc && ~io_rdn) rdata_reg <= '0;
    end
  end

  assign io_ready = (state_reg == ST_RESP);
  assign io_rdata = rdata_reg;
  assign disp_num = disp_reg;
  assign led      = led_reg;

endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder: register map, button events, held reads,
// timer wrap/compare and reset during a response.
module tb_io_bus_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_sel;
  logic [2:0]  io_addr;
  logic [31:0] io_wdata;
  logic        io_wr;
  logic        io_rdn;
  logic [31:0] io_rdata;
  logic        io_ready;
  logic [7:0]  sw;
  logic [4:0]  btn;
  logic [31:0] disp_num;
  logic [7:0]  led;

  int n_cmp = 0;
  int n_bad = 0;

  io_bus_responder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_sel   (io_sel),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wr    (io_wr),
    .io_rdn   (io_rdn),
    .io_rdata (io_rdata),
    .io_ready (io_ready),
    .sw       (sw),
    .btn      (btn),
    .disp_num (disp_num),
    .led      (led)
  );

  always #5 clk = ~clk;

  task automatic bus_start(input logic wr, input logic rd, input logic [2:0] a,
                           input logic [31:0] d);
    @(negedge clk);
    io_sel   = 1'b1;
    io_wr    = wr;
    io_rdn   = ~rd;
    io_addr  = a;
    io_wdata = d;
  endtask

  task automatic bus_finish(output logic [31:0] rd, output int lat, output logic ready_after);
    lat = -1;
    rd  = 32'hDEAD_DEAD;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (io_ready) begin
        lat = c;
        rd  = io_rdata;
        break;
      end
    end
    io_sel = 1'b0;
    io_wr  = 1'b0;
    io_rdn = 1'b1;
    @(negedge clk);
    ready_after = io_ready;
    $display("xfer addr=%0d rdata=%h lat=%0d", io_addr, rd, lat);
  endtask

  task automatic bus_xfer(input logic wr, input logic rd, input logic [2:0] a,
                          input logic [31:0] d, output logic [31:0] rdv, output int lat,
                          output logic ready_after);
    bus_start(wr, rd, a, d);
    bus_finish(rdv, lat, ready_after);
  endtask

  task automatic test_reset();
    logic [31:0] exp_tab [8];
    logic [31:0] rdv;
    int          lat;
    logic        ra;
    exp_tab = '{32'h0, 32'h0, 32'h0000_00A5, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    repeat (3) @(negedge clk);
    n_cmp++; if (io_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", io_ready); end
    n_cmp++; if (disp_num !== 32'h0) begin n_bad++; $display("FAIL rst_disp got=%h exp=0", disp_num); end
    n_cmp++; if (led !== 8'h0) begin n_bad++; $display("FAIL rst_led got=%h exp=0", led); end
    n_cmp++; if (io_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata got=%h exp=0", io_rdata); end
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      if (a == 5) continue;  // timer value depends on elapsed cycles
      bus_xfer(1'b0, 1'b1, 3'(a), 32'h0, rdv, lat, ra);
      n_cmp++; if (rdv !== exp_tab[a]) begin n_bad++; $display("FAIL rst_read[%0d] got=%h exp=%h", a, rdv, exp_tab[a]); end
      n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rst_lat[%0d] got=%0d exp=1", a, lat); end
      n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL rst_one_pulse[%0d] got=%b exp=0", a, ra); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] rdv;
    int          lat;
    logic        ra;
    bus_xfer(1'b1, 1'b0, 3'd0, 32'h1234_5678, rdv, lat, ra);
    n_cmp++; if (disp_num !== 32'h1234_5678) begin n_bad++; $display("FAIL disp_out got=%h exp=12345678", disp_num); end
    bus_xfer(1'b1, 1'b0, 3'd1, 32'h0000_01FF, rdv, lat, ra);
    n_cmp++; if (led !== 8'hFF) begin n_bad++; $display("FAIL led_out got=%h exp=ff", led); end
    bus_xfer(1'b0, 1'b1, 3'd1, 32'h0, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h0000_00FF) begin n_bad++; $display("FAIL led_read got=%h exp=000000ff", rdv); end
    bus_xfer(1'b0, 1'b1, 3'd0, 32'h0, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h1234_5678) begin n_bad++; $display("FAIL disp_read got=%h exp=12345678", rdv); end
    bus_xfer(1'b1, 1'b0, 3'd2, 32'h0000_0011, rdv, lat, ra);
    n_cmp++; if (io_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL wr_keeps_rdata got=%h exp=12345678", io_rdata); end
    bus_xfer(1'b0, 1'b1, 3'd2, 32'h0, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h0000_00A5) begin n_bad++; $display("FAIL sw_ro got=%h exp=000000a5", rdv); end
    bus_xfer(1'b1, 1'b1, 3'd1, 32'h0000_003C, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h0) begin n_bad++; $display("FAIL wr_rd_collide_rdata got=%h exp=0", rdv); end
    n_cmp++; if (led !== 8'h3C) begin n_bad++; $display("FAIL wr_rd_collide_led got=%h exp=3c", led); end
  endtask

  task automatic test_btn_edge();
    logic [31:0] rdv;
    int          lat;
    logic        ra;
    @(negedge clk); btn = 5'b01000;
    @(negedge clk); btn = 5'b00000;
    bus_xfer(1'b0, 1'b1, 3'd3, 32'h0, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h08) begin n_bad++; $display("FAIL evt_first got=%h exp=08", rdv); end
    bus_xfer(1'b0, 1'b1, 3'd3, 32'h0, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h0) begin n_bad++; $display("FAIL evt_cleared got=%h exp=0", rdv); end
    // Rising edge lands on the same edge as the read-clear.
    bus_start(1'b0, 1'b1, 3'd3, 32'h0);
    btn = 5'b01000;
    bus_finish(rdv, lat, ra);
    btn = 5'b00000;
    n_cmp++; if (rdv !== 32'h0) begin n_bad++; $display("FAIL evt_collide_read got=%h exp=0", rdv); end
    bus_xfer(1'b0, 1'b1, 3'd3, 32'h0, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h08) begin n_bad++; $display("FAIL evt_set_wins got=%h exp=08", rdv); end
    n_cmp++; if (rdv[4:0] !== 5'b01000 || lat !== 1) begin n_bad++; $display("FAIL evt_lvl_lat got=%0d exp=1", lat); end
  endtask

  task automatic test_held_read();
    logic [31:0] rdv;
    logic [31:0] held_rd;
    int          pulses;
    int          lat;
    logic        ra;
    @(negedge clk); btn = 5'b00001;
    @(negedge clk); btn = 5'b00000;
    bus_start(1'b0, 1'b1, 3'd3, 32'h0);
    pulses  = 0;
    held_rd = 32'hDEAD_DEAD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (io_ready) begin
        pulses++;
        held_rd = io_rdata;
      end
      if (i == 2) btn = 5'b00010;
      if (i == 3) btn = 5'b00000;
    end
    io_sel = 1'b0;
    io_rdn = 1'b1;
    $display("held read rdata=%h pulses=%0d", held_rd, pulses);
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL held_pulses got=%0d exp=1", pulses); end
    n_cmp++; if (held_rd !== 32'h01) begin n_bad++; $display("FAIL held_rdata got=%h exp=01", held_rd); end
    bus_xfer(1'b0, 1'b1, 3'd3, 32'h0, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h02) begin n_bad++; $display("FAIL held_new_edge got=%h exp=02", rdv); end
  endtask

  task automatic test_timer();
    logic [31:0] rdv;
    int          lat;
    logic        ra;
    bus_xfer(1'b1, 1'b0, 3'd6, 32'h0000_0001, rdv, lat, ra);
    bus_xfer(1'b0, 1'b1, 3'd7, 32'h0, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h0) begin n_bad++; $display("FAIL status_idle got=%h exp=0", rdv); end
    bus_xfer(1'b1, 1'b0, 3'd5, 32'hFFFF_FFFE, rdv, lat, ra);
    // Load, +1 -> FFFFFFFF, +1 -> 0; the next read captures 0.
    bus_xfer(1'b0, 1'b1, 3'd5, 32'h0, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h0) begin n_bad++; $display("FAIL timer_wrap got=%h exp=0", rdv); end
    bus_xfer(1'b0, 1'b1, 3'd7, 32'h0, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h1) begin n_bad++; $display("FAIL status_match got=%h exp=1", rdv); end
    bus_xfer(1'b1, 1'b0, 3'd7, 32'h0000_0001, rdv, lat, ra);
    bus_xfer(1'b0, 1'b1, 3'd7, 32'h0, rdv, lat, ra);
    n_cmp++; if (rdv !== 32'h0) begin n_bad++; $display("FAIL status_w1c got=%h exp=0", rdv); end
  endtask

  task automatic test_reset_mid_resp();
    logic [31:0] rdv;
    int          lat;
    logic        ra;
    bus_start(1'b0, 1'b1, 3'd6, 32'h0);
    @(negedge clk);
    n_cmp++; if (io_ready !== 1'b1 || io_rdata !== 32'h1) begin n_bad++; $display("FAIL pre_rst_resp got=%b/%h exp=1/00000001", io_ready, io_rdata); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (io_ready !== 1'b0) begin n_bad++; $display("FAIL rst_async_ready got=%b exp=0", io_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus_finish(rdv, lat, ra);
    n_cmp++; if (lat !== 1) begin n_bad++; $display("FAIL rst_reserve_lat got=%0d exp=1", lat); end
    n_cmp++; if (rdv !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL rst_reserve_data got=%h exp=ffffffff", rdv); end
    n_cmp++; if (ra !== 1'b0) begin n_bad++; $display("FAIL rst_reserve_pulse got=%b exp=0", ra); end
  endtask

  initial begin
    rst_n    = 1'b0;
    io_sel   = 1'b0;
    io_addr  = 3'd0;
    io_wdata = 32'h0;
    io_wr    = 1'b0;
    io_rdn   = 1'b1;
    sw       = 8'hA5;
    btn      = 5'b00000;
    test_reset();
    test_regs();
    test_btn_edge();
    test_held_read();
    test_timer();
    test_reset_mid_resp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
- Memory-mapped I/O responder answering the multi-cycle CPU's I/O reads and writes.
- Owns the display word fed to seven_seg, plus the LED register.
- Exposes switches, debounced buttons with sticky edge capture, and a free-running timer with compare match.
- Sits between the CPU I/O strobes and the board peripherals, replacing hard-wired button/LED logic in top.

Parameters:
- BTN_N, 5, number of debounced button inputs.
- SW_N, 8, number of switch inputs.
- CMP_RESET, 32'hFFFF_FFFF, reset value of the timer compare register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- io_sel  in  1  CPU address decodes into I/O space.
- io_addr  in  3  word offset (CPU address bits [4:2]).
- io_wdata  in  32  write data from CPU.
- io_wr  in  1  write request, active-high level, held until io_ready.
- io_rdn  in  1  read request, active-low level, held until io_ready.
- io_rdata  out  32  read data, valid while io_ready=1 on a read.
- io_ready  out  1  one-cycle completion pulse.
- sw  in  SW_N  board switches (already stable).
- btn  in  BTN_N  debounced button levels.
- disp_num  out  32  value for seven_seg.
- led  out  8  LED drive.

Behaviour:
- Reset (async, rst_n=0):
  - disp_num=0, led=0, io_rdata=0, io_ready=0.
  - evt=0, btn_q=0, timer=0, cmp=CMP_RESET, match=0.
  - FSM=IDLE.
- Register map by io_addr:
  - 0 DISP: R/W, 32 bits.
  - 1 LED: R/W, bits[7:0]; reads zero-extend.
  - 2 SW: RO, zero-extended; writes ignored.
  - 3 BTN_EVT: sticky rising-edge flags [BTN_N-1:0].
    - Read returns the flags, then clears them.
    - Write is 1-to-clear.
  - 4 BTN_LVL: RO, current btn.
  - 5 TIMER: R/W; increments by 1 every clk, wraps FFFF_FFFF->0.
  - 6 CMP: R/W.
  - 7 STATUS: bit0=match sticky, W1C; other bits read 0.
- Edge capture:
  - btn_q <= btn every cycle.
  - evt[i] sets when btn[i]&~btn_q[i].
  - When a set and a clear (read or W1C) hit the same cycle, set wins.
- Timer:
  - A CPU write to TIMER loads io_wdata; the write wins over the increment that cycle.
  - match sets in any cycle with timer==cmp (pre-increment value).
  - A set and a W1C of match in the same cycle: set wins.
- FSM states IDLE, RESP, HOLD:
  - IDLE:
    - Request = io_sel & (io_wr | ~io_rdn).
    - On a request, perform the access at this edge: register update, or capture read data and apply side effects. Go to RESP.
    - Write has priority when io_wr and ~io_rdn are both asserted; the read is dropped and rdata=0.
  - RESP: io_ready=1 for exactly this cycle; io_rdata holds captured data. Go to HOLD.
  - HOLD: io_ready=0. Return to IDLE once (io_wr=0 & io_rdn=1) or io_sel=0.
    - Guarantees one access per request, so a held read never double-clears BTN_EVT.
- Latency: access at request edge +0; io_ready high in the following cycle.
  - Minimum two cycles between accepted requests (request, RESP, HOLD release).
- io_rdata holds its last value outside RESP. Writes leave io_rdata unchanged.
- Reset mid-transaction:
  - Aborts immediately: io_ready=0, FSM=IDLE.
  - A request still held after reset release is serviced as new.

Decomposition:
- Shared package holds:
  - register offset constants REG_DISP..REG_STATUS (3-bit);
  - FSM state encoding (2-bit: IDLE=0, RESP=1, HOLD=2);
  - CMP_RESET default.
- One natural sub-module: btn_edge_capture (btn_q, evt set/clear with set-priority), instantiated once with width BTN_N.

Test Plan:
- Reset, then read all 8 offsets with sw=8'hA5 -> DISP=0, LED=0, SW=0x000000A5, EVT=0, LVL=0, CMP=0xFFFFFFFF, STATUS=0; each read gives exactly one io_ready pulse, one cycle after the request.
- Write DISP=0x12345678, then LED=0x1FF -> disp_num=0x12345678, led=0xFF; readback LED=0x000000FF.
- Pulse btn[3] 0->1->0 -> EVT read=0x08, second read=0; rising edge in the same cycle as the read-clear -> next read=0x08.
- Hold io_rdn low 5 cycles on BTN_EVT with evt=0x01 -> single io_ready, rdata=0x01, evt cleared once; a new edge during HOLD is retained.
- Write TIMER=0xFFFFFFFE, CMP=0x00000001 -> timer wraps through 0; STATUS bit0 sets 3 cycles after the load; W1C STATUS clears it.
- Assert rst_n=0 during RESP -> io_ready drops asynchronously; after release, the held read is re-served with post-reset values.
